iob_mem_arbiter: RTL and testbench
==================================

// Module: iob_mem_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory/bus port between the core
//  instruction-fetch (I) and data (D) interfaces. Sits between the core and the
//  external memory path. Registers the winning request, issues it with a req/gnt
//  handshake and returns the response on the originating interface.
//  Exactly one transaction is outstanding at any time.
// PARAMETERS
//  AW            32   address width
//  DW            32   data width
//  TAGW          11   D request/response tag width
//  STARVE_LIMIT  4    max consecutive D grants while I is pending (>=1)
//  TIMEOUT_CYC   256  WAIT watchdog limit; used only with IOB_ARB_TIMEOUT_EN
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, asynchronous, active-high
//  i_ren          in   1     I fetch request
//  i_addr         in   AW    I fetch address
//  i_accept       out  1     I request captured this cycle
//  i_val          out  1     I response valid (1-cycle pulse)
//  i_rdata        out  DW    I fetch data
//  i_pc           out  AW    address of the returned fetch
//  i_error        out  1     I response error
//  d_ren          in   1     D read request
//  d_wen          in   4     D byte write enables (non-zero = write)
//  d_addr         in   AW    D address
//  d_wdata        in   DW    D write data
//  d_req_tag      in   TAGW  D request tag
//  d_accept       out  1     D request captured this cycle
//  d_val          out  1     D response valid (1-cycle pulse)
//  d_rdata        out  DW    D read data (0 for writes)
//  d_resp_tag     out  TAGW  tag of the returned D response
//  d_error        out  1     D response error
//  mem_req        out  1     memory request; held until mem_gnt
//  mem_we         out  4     byte write enables (0 = read)
//  mem_addr       out  AW    memory address
//  mem_wdata      out  DW    memory write data
//  mem_gnt        in   1     memory accepted request
//  mem_rvalid     in   1     memory response (reads and writes)
//  mem_rdata      in   DW    memory read data
//  mem_err        in   1     memory error, qualified by mem_rvalid
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; starve counter=0; captured request cleared.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if any request, pick winner; winner's accept=1 combinationally, and the
//   request (addr/wdata/we/tag/src) is registered; next state is ISSUE. Loser's accept=0.
//  Priority: D wins over I, except I wins when starve_cnt==STARVE_LIMIT.
//   starve_cnt increments on a D grant while i_ren=1, clears on an I grant,
//   and clears when i_ren=0 in IDLE. It saturates at STARVE_LIMIT.
//  ISSUE: mem_req=1 with registered addr/we/wdata, held stable until mem_gnt.
//   On mem_gnt, next state is WAIT. Reads drive mem_we=0.
//  WAIT: on mem_rvalid, register rdata/err (rdata forced 0 for writes); go to RESP.
//  RESP: exactly one of i_val/d_val =1 for one cycle. i_pc=captured addr;
//   d_resp_tag=captured tag. Next state is IDLE. No accept in ISSUE/WAIT/RESP.
//  Min latency (mem_gnt immediate, rvalid 1 cycle after gnt):
//   accept@N, mem_req@N+1, rvalid@N+2, val@N+3.
//  Accept-to-accept period: 4 cycles minimum.
//  mem_rvalid outside WAIT is discarded.
//  Read data, error, pc and tag hold their values until the next response.
//  rst asserted mid-transaction: immediate return to the reset state; the in-flight
//   memory op is abandoned, because the memory shares rst.
// CONFIGURATION
//  IOB_ARB_TIMEOUT_EN defined: WAIT counts cycles. After TIMEOUT_CYC cycles without
//   mem_rvalid, go to RESP with error=1 and rdata=0. Late rvalid is discarded.
//  IOB_ARB_TIMEOUT_EN undefined: no counter; WAIT is held indefinitely.
// STRUCTURE
//  iob_pkg: arb_state_e {IDLE,ISSUE,WAIT,RESP}, arb_src_e {SRC_I,SRC_D}.
//  iob_pkg also holds default widths AW/DW/TAGW.
//  Sub-module iob_arb_pick: priority + starve counter; outputs grant_i/grant_d.
//  FSM, capture registers and optional watchdog live in the top module.
// TESTING
//  1 D read addr=0x10 tag=0x5, gnt immediate, rvalid rdata=0xDEADBEEF
//    -> d_val 1 cycle, d_rdata=0xDEADBEEF, d_resp_tag=0x5, i_val=0.
//  2 i_ren and d_ren held high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...;
//    i_pc equals the I addr.
//  3 D write wen=4'b0011 addr=0x20 wdata=0xA5A5 -> mem_we=0011, mem_wdata=0xA5A5,
//    d_val with d_rdata=0.
//  4 mem_gnt low for 3 cycles in ISSUE -> mem_req/addr/we stable;
//    no accept while pending.
//  5 rst asserted in WAIT -> all outputs 0 the same cycle; a new I fetch after
//    reset completes normally.
//  6 IOB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no rvalid -> d_error=1, d_rdata=0 after 8
//    WAIT cycles; a late rvalid is ignored.

Source files
------------

// File: rtl/iob_pkg.sv
// Shared types and default widths for the I/D memory arbiter.
package iob_pkg;

  localparam int unsigned DEF_AW   = 32;
  localparam int unsigned DEF_DW   = 32;
  localparam int unsigned DEF_TAGW = 11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic {SRC_I, SRC_D} arb_src_e;

endpackage

// File: rtl/iob_arb_pick.sv
// I/D request priority with a starvation counter that forces an I grant
// after STARVE_LIMIT consecutive D grants while I is waiting.
module iob_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_grant_i,
  output logic o_grant_d
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_i_first;

  assign w_i_first = i_ireq && (r_cnt == LIMIT);
  assign o_grant_d = i_idle && i_dreq && !w_i_first;
  assign o_grant_i = i_idle && i_ireq && !o_grant_d;

  // The counter only moves in IDLE, where grants are decided.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_idle) begin
      if (!i_ireq || o_grant_i) begin
        w_cnt_next = '0;
      end else if (o_grant_d && (r_cnt != LIMIT)) begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/iob_mem_arbiter.sv
// Shares one req/gnt memory port between I-fetch and D interfaces, one transaction
// outstanding. Define IOB_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module iob_mem_arbiter
  import iob_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned TAGW         = DEF_TAGW,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ren,
  input  logic [AW-1:0]   i_addr,
  output logic            i_accept,
  output logic            i_val,
  output logic [DW-1:0]   i_rdata,
  output logic [AW-1:0]   i_pc,
  output logic            i_error,
  input  logic            d_ren,
  input  logic [3:0]      d_wen,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [TAGW-1:0] d_req_tag,
  output logic            d_accept,
  output logic            d_val,
  output logic [DW-1:0]   d_rdata,
  output logic [TAGW-1:0] d_resp_tag,
  output logic            d_error,
  output logic            mem_req,
  output logic [3:0]      mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_err
);

  arb_state_e      r_state, w_state_next;
  arb_src_e        r_src;
  logic [AW-1:0]   r_addr, r_pc;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic [3:0]      r_we;
  logic [TAGW-1:0] r_tag, r_resp_tag;
  logic            r_err;
  logic            w_grant_i, w_grant_d, w_dreq, w_timeout, w_rsp_event;

  assign w_dreq = d_ren || (d_wen != 4'b0000);

  iob_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .i_idle   (r_state == IDLE),
    .i_ireq   (i_ren),
    .i_dreq   (w_dreq),
    .o_grant_i(w_grant_i),
    .o_grant_d(w_grant_d)
  );

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == WAIT) && !mem_rvalid && (r_wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
`endif

  // rvalid outside WAIT never reaches the response registers.
  assign w_rsp_event = (r_state == WAIT) && (mem_rvalid || w_timeout);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_grant_i || w_grant_d) w_state_next = ISSUE;
      ISSUE: if (mem_gnt) w_state_next = WAIT;
      WAIT:  if (w_rsp_event) w_state_next = RESP;
      RESP:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_src      <= SRC_I;
      r_addr     <= '0;
      r_we       <= '0;
      r_wdata    <= '0;
      r_tag      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_pc       <= '0;
      r_resp_tag <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i || w_grant_d) begin
        r_src   <= w_grant_d ? SRC_D : SRC_I;
        r_addr  <= w_grant_d ? d_addr : i_addr;
        r_we    <= w_grant_d ? d_wen : 4'b0000;
        r_wdata <= w_grant_d ? d_wdata : '0;
        if (w_grant_d) r_tag <= d_req_tag;
      end
      if (w_rsp_event) begin
        r_rdata <= (w_timeout || (r_we != 4'b0000)) ? '0 : mem_rdata;
        r_err   <= w_timeout ? 1'b1 : mem_err;
        if (r_src == SRC_I) begin
          r_pc <= r_addr;
        end else begin
          r_resp_tag <= r_tag;
        end
      end
    end
  end

  // Accepts are combinational, so gate them to keep every output low during reset.
  assign i_accept   = w_grant_i && !rst;
  assign d_accept   = w_grant_d && !rst;
  assign i_val      = (r_state == RESP) && (r_src == SRC_I);
  assign d_val      = (r_state == RESP) && (r_src == SRC_D);
  assign i_rdata    = r_rdata;
  assign d_rdata    = r_rdata;
  assign i_error    = r_err;
  assign d_error    = r_err;
  assign i_pc       = r_pc;
  assign d_resp_tag = r_resp_tag;
  assign mem_req    = (r_state == ISSUE);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed bench for iob_mem_arbiter; the timeout sequence runs only when
// IOB_ARB_TIMEOUT_EN is defined.
module tb_iob_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ren = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_accept, i_val, i_error;
  logic [31:0] i_rdata, i_pc;
  logic        d_ren = 1'b0;
  logic [3:0]  d_wen = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [10:0] d_req_tag = '0;
  logic        d_accept, d_val, d_error;
  logic [31:0] d_rdata;
  logic [10:0] d_resp_tag;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_fail = 0;

  iob_mem_arbiter #(
    .AW(32), .DW(32), .TAGW(11), .STARVE_LIMIT(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_accept(i_accept), .i_val(i_val),
    .i_rdata(i_rdata), .i_pc(i_pc), .i_error(i_error),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_req_tag(d_req_tag), .d_accept(d_accept), .d_val(d_val), .d_rdata(d_rdata),
    .d_resp_tag(d_resp_tag), .d_error(d_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Memory model: gnt after m_gdly stalled cycles, rvalid the cycle after gnt.
  int          m_gdly = 0;
  int          m_stall = 0;
  bit          m_rsp_en = 1'b1;
  bit          m_force_rv = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;
  logic        m_prev_req = 1'b0;
  logic [3:0]  m_we_s = '0;
  logic [31:0] m_addr_s = '0, m_wdata_s = '0;

  always @(negedge clk) begin
    mem_rvalid = (m_prev_req && mem_gnt && m_rsp_en) || m_force_rv;
    mem_rdata  = m_rdata;
    mem_err    = m_err;
    mem_gnt    = 1'b0;
    if (mem_req) begin
      if (m_stall < m_gdly) begin
        m_stall++;
      end else begin
        mem_gnt   = 1'b1;
        m_stall   = 0;
        m_we_s    = mem_we;
        m_addr_s  = mem_addr;
        m_wdata_s = mem_wdata;
      end
    end
    m_prev_req = mem_req;
  end

  typedef struct {
    bit          is_d;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    int          gnt_dly;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];
  bit   exp_order_d[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    i_ren = 1'b0;
    d_ren = 1'b0;
    d_wen = 4'b0000;
  endtask

  task automatic wait_accept(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_d ? d_accept : i_accept) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_val(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_val || d_val) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int lat;
    m_gdly = v.gnt_dly; m_rdata = v.rdata; m_err = v.err; m_rsp_en = 1'b1; m_stall = 0;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_ren = (v.wen == 4'b0000); d_wen = v.wen; d_addr = v.addr;
      d_wdata = v.wdata; d_req_tag = v.tag;
    end else begin
      i_ren = 1'b1; i_addr = v.addr;
    end
    wait_accept(v.is_d, ok);
    check("accept", 64'(ok), 1);
    @(posedge clk); #1;
    drive_idle();
    wait_val(lat);
    check("latency", 64'(lat), 64'(2 + v.gnt_dly));
    check("d_val", 64'(d_val), 64'(v.is_d));
    check("i_val", 64'(i_val), 64'(!v.is_d));
    if (v.is_d) begin
      check("d_rdata", 64'(d_rdata), 64'(v.exp_rdata));
      check("d_error", 64'(d_error), 64'(v.exp_err));
      check("d_resp_tag", 64'(d_resp_tag), 64'(v.tag));
    end else begin
      check("i_rdata", 64'(i_rdata), 64'(v.exp_rdata));
      check("i_error", 64'(i_error), 64'(v.exp_err));
      check("i_pc", 64'(i_pc), 64'(v.addr));
    end
    check("mem_addr", 64'(m_addr_s), 64'(v.addr));
    check("mem_we", 64'(m_we_s), 64'(v.wen));
    if (v.wen != 4'b0000) check("mem_wdata", 64'(m_wdata_s), 64'(v.wdata));
    @(negedge clk);
    check("val_pulse", 64'(i_val | d_val), 0);
  endtask

  function automatic logic any_out();
    return |{i_accept, i_val, i_rdata, i_pc, i_error, d_accept, d_val, d_rdata,
             d_resp_tag, d_error, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat, n_acc, last_k;
    bit seen_ival;

    vecs[0] = '{is_d:1, wen:4'h0, addr:32'h10, wdata:32'h0, tag:11'h5, gnt_dly:0,
                rdata:32'hDEADBEEF, err:0, exp_rdata:32'hDEADBEEF, exp_err:0};
    vecs[1] = '{is_d:1, wen:4'b0011, addr:32'h20, wdata:32'hA5A5, tag:11'h6, gnt_dly:0,
                rdata:32'h12345678, err:0, exp_rdata:32'h0, exp_err:0};
    vecs[2] = '{is_d:0, wen:4'h0, addr:32'h100, wdata:32'h0, tag:11'h0, gnt_dly:0,
                rdata:32'h13, err:0, exp_rdata:32'h13, exp_err:0};
    vecs[3] = '{is_d:1, wen:4'h0, addr:32'h24, wdata:32'h0, tag:11'h7FF, gnt_dly:2,
                rdata:32'hCAFEF00D, err:1, exp_rdata:32'hCAFEF00D, exp_err:1};
    vecs[4] = '{is_d:0, wen:4'h0, addr:32'h104, wdata:32'h0, tag:11'h0, gnt_dly:1,
                rdata:32'h55AA55AA, err:1, exp_rdata:32'h55AA55AA, exp_err:1};
    vecs[5] = '{is_d:1, wen:4'b1111, addr:32'h28, wdata:32'h0BADC0DE, tag:11'h100, gnt_dly:1,
                rdata:32'hFFFFFFFF, err:1, exp_rdata:32'h0, exp_err:1};

    // Reset: requests high, yet every output must stay 0.
    i_ren = 1'b1; d_ren = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(any_out()), 0);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Starvation: both held high -> D,D,D,D,I,D with 4-cycle accept spacing.
    m_gdly = 0; m_rsp_en = 1'b1; m_rdata = 32'h1111_0000; m_err = 1'b0; m_stall = 0;
    @(posedge clk); #1;
    i_ren = 1'b1; i_addr = 32'h400; d_ren = 1'b1; d_addr = 32'h800; d_req_tag = 11'h3;
    n_acc = 0; last_k = 0; seen_ival = 1'b0;
    for (int k = 0; k < 80 && n_acc < 6; k++) begin
      @(negedge clk);
      if (i_val) begin
        seen_ival = 1'b1;
        check("starve_i_pc", 64'(i_pc), 64'h400);
      end
      if (i_accept || d_accept) begin
        check("starve_grant", 64'(d_accept), 64'(exp_order_d[n_acc]));
        check("starve_single", 64'(i_accept & d_accept), 0);
        if (n_acc > 0) check("accept_period", 64'(k - last_k), 4);
        last_k = k;
        n_acc++;
      end
    end
    check("starve_accepts", 64'(n_acc), 6);
    check("starve_i_served", 64'(seen_ival), 1);
    @(posedge clk); #1;
    drive_idle();
    repeat (6) @(negedge clk);

    // gnt held low 3 cycles: request stable, I stays pending and unaccepted.
    m_gdly = 3; m_rdata = 32'h7777; m_stall = 0;
    @(posedge clk); #1;
    d_ren = 1'b1; d_addr = 32'h30; d_req_tag = 11'h9; i_ren = 1'b1; i_addr = 32'h500;
    wait_accept(1'b1, ok);
    check("stall_accept", 64'(ok), 1);
    @(posedge clk); #1;
    d_ren = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_req", 64'(mem_req), 1);
      check("stall_addr", 64'(mem_addr), 64'h30);
      check("stall_we", 64'(mem_we), 0);
      check("stall_no_accept", 64'(i_accept | d_accept), 0);
    end
    wait_val(lat);
    check("stall_lat", 64'(lat), 2);
    check("stall_dval", 64'(d_val), 1);
    check("stall_rdata", 64'(d_rdata), 64'h7777);
    m_gdly = 0; m_rdata = 32'h5500;
    wait_accept(1'b0, ok);
    check("pending_i_accept", 64'(ok), 1);
    @(posedge clk); #1;
    i_ren = 1'b0;
    wait_val(lat);
    check("pending_i_val", 64'(i_val), 1);
    check("pending_i_pc", 64'(i_pc), 64'h500);
    check("pending_i_rdata", 64'(i_rdata), 64'h5500);
    check("tag_hold", 64'(d_resp_tag), 64'h9);
    @(negedge clk);

    // Reset while in WAIT.
    m_rsp_en = 1'b0; m_stall = 0;
    @(posedge clk); #1;
    d_ren = 1'b1; d_addr = 32'h40; d_req_tag = 11'h11; i_ren = 1'b1; i_addr = 32'h600;
    wait_accept(1'b1, ok);
    check("rst_accept", 64'(ok), 1);
    @(posedge clk); #1;
    d_ren = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_wait", 64'(mem_req), 0);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 64'(any_out()), 0);
    @(posedge clk); #1;
    drive_idle();
    m_rsp_en = 1'b1; m_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[2]);

`ifdef IOB_ARB_TIMEOUT_EN
    // Watchdog: no rvalid -> error response after 8 WAIT cycles; late rvalid ignored.
    m_rsp_en = 1'b0; m_gdly = 0; m_stall = 0; m_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    d_ren = 1'b1; d_addr = 32'h44; d_req_tag = 11'h2A;
    wait_accept(1'b1, ok);
    check("to_accept", 64'(ok), 1);
    @(posedge clk); #1;
    d_ren = 1'b0;
    wait_val(lat);
    check("to_lat", 64'(lat), 9);
    check("to_dval", 64'(d_val), 1);
    check("to_error", 64'(d_error), 1);
    check("to_rdata", 64'(d_rdata), 0);
    check("to_tag", 64'(d_resp_tag), 64'h2A);
    @(posedge clk); #1;
    m_force_rv = 1'b1;
    @(posedge clk); #1;
    m_force_rv = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("late_rvalid_val", 64'(i_val | d_val), 0);
    end
    check("late_rvalid_rdata", 64'(d_rdata), 0);
    m_rsp_en = 1'b1;
    run_vec(vecs[0]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
